ad7606_frame_packer: RTL
========================

// Module: ad7606_frame_packer
// PURPOSE
//   Consumer stage for the AD7606 driver's per-channel user outputs.
//   - Collects the eight 16-bit channel samples of one conversion into a frame.
//   - Double-buffers the frame.
//   - Emits it as a byte stream with valid/ready/last handshake for a UART/ETH/FIFO sink.
//   - Counts dropped and malformed frames.
// PARAMETERS
//   P_HEAD        16'hA55A  frame header, sent MSB byte first
//   P_DROP_CNT_W  16        width of the saturating drop/error counters
// PORTS
//   i_clk            in   1             system clock (50 MHz, same as driver)
//   i_rst_n          in   1             async active-low reset
//   i_user_data_1..8 in   16 each       channel samples from driver
//   i_user_valid_1..8 in  1 each        1-cycle strobe per channel sample
//   o_tdata          out  8             stream byte
//   o_tvalid         out  1             byte valid
//   i_tready         in   1             sink ready
//   o_tlast          out  1             high on final byte of frame
//   o_drop_cnt       out  P_DROP_CNT_W  frames lost because tx buffer full
//   o_err_cnt        out  P_DROP_CNT_W  frames discarded as incomplete
// BEHAVIOUR
//   Reset: all outputs 0 (o_tvalid=0, o_tlast=0, counters=0, seq=0); capture mask, buffers and FSM cleared.
//   Capture
//     - valid_k high: data_k stored in capture buffer slot k-1, mask bit k-1 set.
//     - A repeated valid_k before frame end overwrites the slot.
//   Frame end = valid_8 sampled.
//     - All 8 mask bits set (incl. this cycle) and tx buffer free:
//       buffer copied to tx buffer, seq latched.
//     - All 8 set but tx buffer busy: frame dropped, o_drop_cnt+1 (saturating), seq unchanged.
//     - Any mask bit missing: frame discarded, o_err_cnt+1 (saturating).
//     - Mask cleared at every frame end regardless of outcome.
//   Tx buffer is free when the FSM is in IDLE, or when it completes the last byte
//   (o_tvalid&&i_tready&&o_tlast) in the same cycle as the frame end.
//   A simultaneous end and accept is NOT a drop.
//   FSM: IDLE -> HDR0 -> HDR1 -> SEQ -> DATA(16 bytes) [-> CSUM] -> IDLE.
//     - Each state advances only on o_tvalid&&i_tready.
//     - o_tvalid rises the cycle after the accepted valid_8; first byte = P_HEAD[15:8].
//     - Back-to-back frames: IDLE is skipped.
//   Byte order: P_HEAD[15:8], P_HEAD[7:0], seq[7:0], ch1[15:8], ch1[7:0] .. ch8[7:0].
//   Handshake: o_tdata/o_tlast held stable while o_tvalid&&!i_tready; o_tvalid never drops mid-frame.
//   seq increments by 1 per accepted frame, wraps 255->0.
//   Counters saturate at all-ones.
//   i_rst_n low mid-frame: stream aborts immediately; no partial tlast.
// CONFIGURATION
//   AD_FRAME_CHKSUM_EN
//     - Defined: a CSUM byte is appended = 8-bit sum mod 256 of the seq byte and 16 data bytes.
//       Frame is 20 bytes; o_tlast on CSUM.
//     - Undefined: frame is 19 bytes; o_tlast on ch8[7:0]; no adder logic.
// STRUCTURE
//   Shared include ad7606_defs.vh holds:
//     - channel count (8)
//     - frame length constants (19/20)
//     - FSM state encodings
//     - default header 16'hA55A
//   Sub-module ad7606_frame_ser: tx buffer + byte FSM + checksum.
//     - Load port: i_load, i_frame[127:0], i_seq[7:0], o_busy.
//   Top does capture, mask, drop/err counting and seq.
// TESTING
//   1. Ramp ch1..8 = 16'h0101..16'h0808, tready=1
//      -> 19 bytes A5 5A 00 01 01 .. 08 08, tlast on byte 19, tvalid 1 cycle after valid_8.
//   2. tready toggled 1/0 each cycle during frame
//      -> tdata stable while stalled, byte sequence identical to test 1.
//   3. tready=0 held; two complete frames -> 1st held in tx buffer, 2nd dropped.
//      o_drop_cnt=1; release -> seq 00 sent, next accepted frame carries seq 01.
//   4. Frame with valid_3 omitted -> no output, o_err_cnt=1, next full frame sent normally.
//   5. Frame end on the same cycle as previous tlast handshake -> accepted, drop_cnt stays 0.
//   6. With AD_FRAME_CHKSUM_EN, ch all 16'hFFFF, seq 00 -> CSUM byte = 8'hF0 with tlast;
//      also i_rst_n pulse mid-frame -> tvalid=0 at once, seq=0 afterwards.

Source files
------------

// File: rtl/ad7606_frame_packer_pkg.sv
// Shared constants for the AD7606 frame packer: channel count, frame lengths, header, serializer states.
// AD_FRAME_CHKSUM_EN selects the 20-byte frame (with trailing checksum) instead of 19 bytes.
package ad7606_frame_packer_pkg;

    localparam int          AD_NUM_CH         = 8;
    localparam int          AD_FRAME_LEN_BASE = 19;
    localparam int          AD_FRAME_LEN_CSUM = 20;
    localparam logic [15:0] AD_DEFAULT_HEAD   = 16'hA55A;

`ifdef AD_FRAME_CHKSUM_EN
    localparam int          AD_FRAME_LEN      = AD_FRAME_LEN_CSUM;
`else
    localparam int          AD_FRAME_LEN      = AD_FRAME_LEN_BASE;
`endif

    typedef enum logic [2:0] {
        SER_IDLE,
        SER_HDR0,
        SER_HDR1,
        SER_SEQ,
        SER_DATA,
        SER_CSUM
    } ser_state_e;

endpackage

// File: rtl/ad7606_frame_packer_ser.sv
// Tx frame buffer and byte serializer with valid/ready/last handshake.
// AD_FRAME_CHKSUM_EN appends a mod-256 checksum byte over seq and the 16 data bytes.
module ad7606_frame_ser
    import ad7606_frame_packer_pkg::*;
#(
    parameter logic [15:0] P_HEAD = AD_DEFAULT_HEAD
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [127:0] i_frame,
    input  logic [7:0]   i_seq,
    output logic         o_busy,
    output logic         o_done,
    output logic [7:0]   o_tdata,
    output logic         o_tvalid,
    input  logic         i_tready,
    output logic         o_tlast
);

    ser_state_e   state_q, state_d;
    logic [127:0] buf_q, buf_d;
    logic [7:0]   seq_q, seq_d;
    logic [4:0]   pos_q, pos_d;
    logic         accept;
`ifdef AD_FRAME_CHKSUM_EN
    logic [7:0]   csum_q, csum_d;
`endif

    assign o_tvalid = (state_q != SER_IDLE);
    assign accept   = o_tvalid && i_tready;
    assign o_busy   = o_tvalid;
    assign o_tlast  = o_tvalid && (pos_q == 5'(AD_FRAME_LEN - 1));
    assign o_done   = accept && o_tlast;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        seq_d   = seq_q;
        pos_d   = pos_q;
        o_tdata = 8'h00;
`ifdef AD_FRAME_CHKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            SER_HDR0: begin
                o_tdata = P_HEAD[15:8];
                if (accept) state_d = SER_HDR1;
            end
            SER_HDR1: begin
                o_tdata = P_HEAD[7:0];
                if (accept) state_d = SER_SEQ;
            end
            SER_SEQ: begin
                o_tdata = seq_q;
                if (accept) state_d = SER_DATA;
            end
            // Data leaves MSB-first; the buffer shifts one byte per accepted beat.
            SER_DATA: begin
                o_tdata = buf_q[127:120];
                if (accept) begin
                    buf_d = {buf_q[119:0], 8'h00};
`ifdef AD_FRAME_CHKSUM_EN
                    csum_d = csum_q + buf_q[127:120];
                    if (pos_q == 5'(AD_FRAME_LEN_BASE - 1)) state_d = SER_CSUM;
`else
                    if (pos_q == 5'(AD_FRAME_LEN_BASE - 1)) state_d = SER_IDLE;
`endif
                end
            end
`ifdef AD_FRAME_CHKSUM_EN
            SER_CSUM: begin
                o_tdata = csum_q;
                if (accept) state_d = SER_IDLE;
            end
`endif
            default: ;
        endcase
        if (accept) pos_d = pos_q + 5'd1;
        // A load coincides only with IDLE or the final accepted byte, so it may override the advance.
        if (i_load) begin
            state_d = SER_HDR0;
            buf_d   = i_frame;
            seq_d   = i_seq;
            pos_d   = '0;
`ifdef AD_FRAME_CHKSUM_EN
            csum_d  = i_seq;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= SER_IDLE;
            buf_q   <= '0;
            seq_q   <= '0;
            pos_q   <= '0;
`ifdef AD_FRAME_CHKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            seq_q   <= seq_d;
            pos_q   <= pos_d;
`ifdef AD_FRAME_CHKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: rtl/ad7606_frame_packer.sv
// Collects eight AD7606 channel samples into a frame, tracks seq/drop/error counts, feeds the serializer.
// AD_FRAME_CHKSUM_EN (see serializer) adds a checksum byte to every frame.
module ad7606_frame_packer
    import ad7606_frame_packer_pkg::*;
#(
    parameter logic [15:0] P_HEAD       = AD_DEFAULT_HEAD,
    parameter int          P_DROP_CNT_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [15:0]             i_user_data_1,
    input  logic [15:0]             i_user_data_2,
    input  logic [15:0]             i_user_data_3,
    input  logic [15:0]             i_user_data_4,
    input  logic [15:0]             i_user_data_5,
    input  logic [15:0]             i_user_data_6,
    input  logic [15:0]             i_user_data_7,
    input  logic [15:0]             i_user_data_8,
    input  logic                    i_user_valid_1,
    input  logic                    i_user_valid_2,
    input  logic                    i_user_valid_3,
    input  logic                    i_user_valid_4,
    input  logic                    i_user_valid_5,
    input  logic                    i_user_valid_6,
    input  logic                    i_user_valid_7,
    input  logic                    i_user_valid_8,
    output logic [7:0]              o_tdata,
    output logic                    o_tvalid,
    input  logic                    i_tready,
    output logic                    o_tlast,
    output logic [P_DROP_CNT_W-1:0] o_drop_cnt,
    output logic [P_DROP_CNT_W-1:0] o_err_cnt
);

    logic [AD_NUM_CH-1:0]    vld;
    logic [15:0]             din   [AD_NUM_CH];
    logic [15:0]             cap_q [AD_NUM_CH];
    logic [15:0]             cap_d [AD_NUM_CH];
    logic [AD_NUM_CH-1:0]    mask_q, mask_d, mask_set;
    logic [7:0]              seq_q, seq_d;
    logic [P_DROP_CNT_W-1:0] drop_q, drop_d, err_q, err_d;
    logic [127:0]            frame;
    logic                    frame_end, frame_full, tx_busy, tx_done, tx_free, load;

    function automatic logic [P_DROP_CNT_W-1:0] sat_inc(input logic [P_DROP_CNT_W-1:0] v);
        return (&v) ? v : v + {{(P_DROP_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign vld = {i_user_valid_8, i_user_valid_7, i_user_valid_6, i_user_valid_5,
                  i_user_valid_4, i_user_valid_3, i_user_valid_2, i_user_valid_1};
    assign din[0] = i_user_data_1;
    assign din[1] = i_user_data_2;
    assign din[2] = i_user_data_3;
    assign din[3] = i_user_data_4;
    assign din[4] = i_user_data_5;
    assign din[5] = i_user_data_6;
    assign din[6] = i_user_data_7;
    assign din[7] = i_user_data_8;

    // The frame end cycle's own strobes count toward completeness and frame contents.
    assign mask_set   = mask_q | vld;
    assign frame_end  = vld[AD_NUM_CH-1];
    assign frame_full = &mask_set;
    assign tx_free    = !tx_busy || tx_done;
    assign load       = frame_end && frame_full && tx_free;

    always_comb begin
        cap_d  = cap_q;
        frame  = '0;
        for (int k = 0; k < AD_NUM_CH; k++) begin
            if (vld[k]) cap_d[k] = din[k];
            frame[16*(AD_NUM_CH-1-k) +: 16] = cap_d[k];
        end
        mask_d = frame_end ? '0 : mask_set;
        seq_d  = load ? seq_q + 8'd1 : seq_q;
        drop_d = (frame_end && frame_full && !tx_free) ? sat_inc(drop_q) : drop_q;
        err_d  = (frame_end && !frame_full) ? sat_inc(err_q) : err_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < AD_NUM_CH; k++) cap_q[k] <= '0;
            mask_q <= '0;
            seq_q  <= '0;
            drop_q <= '0;
            err_q  <= '0;
        end else begin
            cap_q  <= cap_d;
            mask_q <= mask_d;
            seq_q  <= seq_d;
            drop_q <= drop_d;
            err_q  <= err_d;
        end
    end

    assign o_drop_cnt = drop_q;
    assign o_err_cnt  = err_q;

    ad7606_frame_ser #(
        .P_HEAD (P_HEAD)
    ) u_ser (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (load),
        .i_frame  (frame),
        .i_seq    (seq_q),
        .o_busy   (tx_busy),
        .o_done   (tx_done),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .i_tready (i_tready),
        .o_tlast  (o_tlast)
    );

endmodule
